// File: rtl/mcac_pkg.sv
// mcac_pkg: shared scale-factor limits, slow-filter reset value and channel index type
package mcac_pkg;
    localparam logic [12:0] YU_MIN = 13'd544;
    localparam logic [12:0] YU_MAX = 13'd5120;
    typedef logic [3:0] ch_t;
    function automatic logic [31:0] yl_rst(input int ss);
        return 32'd544 << ss;
    endfunction
endpackage

// File: rtl/yu_fast_filt.sv
// yu_fast_filt: fast scale-factor update YUT = Y + ((WI<<SF) - Y) >>> SF, wrapped to 13 bits
module yu_fast_filt #(
    parameter int SF = 5
) (
    input  logic [11:0] wi_i,
    input  logic [12:0] y_i,
    output logic [12:0] yut_o
);
    localparam int DW = 12 + SF;
    logic [DW-1:0] dif;
    logic signed [DW-1:0] dif_sh;
    assign dif = {wi_i, {SF{1'b0}}} - DW'(y_i);
    assign dif_sh = $signed(dif) >>> SF;
    assign yut_o = y_i + 13'(dif_sh);
endmodule

// File: rtl/yu_filt_mc.sv
// yu_filt_mc: multi-channel 2-stage fast/slow scale-factor filter with per-channel YL table.
// Define YU_LIMB_EN to clamp YU to [YU_MIN, YU_MAX].
module yu_filt_mc
    import mcac_pkg::*;
#(
    parameter int NCH = 4,
    parameter int CHW = 2,
    parameter int SF  = 5,
    parameter int SS  = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CHW-1:0]    in_ch,
    input  logic [11:0]       WI,
    input  logic [12:0]       Y,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CHW-1:0]    out_ch,
    output logic [12:0]       YU,
    output logic [13+SS-1:0]  YLP
);
    localparam int YLW = 13 + SS;
    localparam logic [YLW-1:0] YL_RST = YLW'(yl_rst(SS));

    logic [YLW-1:0] yl_q [NCH];
    logic           s1_v_q, s1_v_d, s2_v_q, s2_v_d;
    logic [CHW-1:0] s1_ch_q, s2_ch_q, ch_d;
    logic [12:0]    s1_yu_q, s2_yu_q, yut, yu_d;
    logic [YLW-1:0] s1_yl_q, s2_ylp_q, s1_yl_d, ylp_d, tbl_rd;
    logic           s2_ld, accept, fwd;
    ch_t            ch_sel;

    yu_fast_filt #(.SF(SF)) u_fast (
        .wi_i  (WI),
        .y_i   (Y),
        .yut_o (yut)
    );

`ifdef YU_LIMB_EN
    assign yu_d = (yut < YU_MIN) ? YU_MIN : (yut > YU_MAX) ? YU_MAX : yut;
`else
    assign yu_d = yut;
`endif

    assign ch_sel = (int'(in_ch) >= NCH) ? ch_t'(NCH - 1) : ch_t'(in_ch);
    assign ch_d   = CHW'(ch_sel);

    assign s2_ld    = s1_v_q && (!s2_v_q || out_ready);
    assign in_ready = !reset && (!s1_v_q || !s2_v_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign s1_v_d   = accept || (s1_v_q && !s2_ld);
    assign s2_v_d   = s2_ld || (s2_v_q && !out_ready);
    assign ylp_d    = s1_yl_q + YLW'(s1_yu_q) - (s1_yl_q >> SS);

    always_comb begin
        tbl_rd = '0;
        for (int c = 0; c < NCH; c++) tbl_rd = (CHW'(c) == ch_d) ? yl_q[c] : tbl_rd;
    end

    // The entry leaving S1 this edge has not yet reached the table; take its result instead
    assign fwd     = s2_ld && (s1_ch_q == ch_d);
    assign s1_yl_d = fwd ? ylp_d : tbl_rd;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_v_q   <= 1'b0;
            s2_v_q   <= 1'b0;
            s2_ch_q  <= '0;
            s2_yu_q  <= '0;
            s2_ylp_q <= '0;
            for (int c = 0; c < NCH; c++) yl_q[c] <= YL_RST;
        end else begin
            s1_v_q <= s1_v_d;
            s2_v_q <= s2_v_d;
            if (accept) begin
                s1_ch_q <= ch_d;
                s1_yu_q <= yu_d;
                s1_yl_q <= s1_yl_d;
            end
            if (s2_ld) begin
                s2_ch_q  <= s1_ch_q;
                s2_yu_q  <= s1_yu_q;
                s2_ylp_q <= ylp_d;
                for (int c = 0; c < NCH; c++) if (CHW'(c) == s1_ch_q) yl_q[c] <= ylp_d;
            end
        end
    end

    assign out_valid = s2_v_q;
    assign out_ch    = s2_ch_q;
    assign YU        = s2_yu_q;
    assign YLP       = s2_ylp_q;
endmodule

// File: tb/tb_yu_filt_mc.sv
// tb_yu_filt_mc: randomized and directed checks of yu_filt_mc against an arithmetic reference model
module tb_yu_filt_mc;
    localparam int NCH = 4, CHW = 2, SF = 5, SS = 6, YLW = 13 + SS;

    typedef struct {int ch; int yu; longint ylp;} res_t;

    logic           clk = 1'b0, reset = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
    logic           in_ready, out_valid;
    logic [CHW-1:0] in_ch = '0, out_ch;
    logic [11:0]    WI = '0;
    logic [12:0]    Y = '0, YU;
    logic [YLW-1:0] YLP;

    int      n_chk = 0, n_pass = 0;
    longint  yl_m [NCH];
    res_t    exp_q [$];
    longint  pop_ylp [$];
    int      pop_yu [$];
    logic    held = 1'b0, acc, ov, rdy;
    logic [12:0]    h_yu;
    logic [YLW-1:0] h_ylp;
    logic [CHW-1:0] h_ch;
    int      sent;

    always #5 clk = ~clk;

    yu_filt_mc #(.NCH(NCH), .CHW(CHW), .SF(SF), .SS(SS)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ch     (in_ch),
        .WI        (WI),
        .Y         (Y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ch    (out_ch),
        .YU        (YU),
        .YLP       (YLP)
    );

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic int m_yu(input int wi, input int y);
        int wis = (wi >= 2048) ? wi - 4096 : wi;
        int m = 1 << (12 + SF);
        int d = wis * (1 << SF) - y;
        int q, yut;
        d = ((d % m) + m) % m;
        if (d >= m / 2) d -= m;
        q = (d >= 0) ? d / (1 << SF) : -((-d + (1 << SF) - 1) / (1 << SF));
        yut = (y + q) & 8191;
`ifdef YU_LIMB_EN
        yut = (yut < 544) ? 544 : (yut > 5120) ? 5120 : yut;
`endif
        return yut;
    endfunction

    task automatic m_reset();
        for (int c = 0; c < NCH; c++) yl_m[c] = longint'(544) << SS;
        exp_q.delete();
        pop_ylp.delete();
        pop_yu.delete();
    endtask

    task automatic cyc(input logic v, input int ch, input int wi, input int y, input logic ordy);
        res_t e;
        int c, yu;
        longint ylp;
        in_valid = v; in_ch = CHW'(ch); WI = 12'(wi); Y = 13'(y); out_ready = ordy;
        @(negedge clk);
        ov = out_valid;
        rdy = in_ready;
        acc = in_valid && in_ready;
        if (held) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_yu", YU, h_yu);
            chk("hold_ylp", YLP, h_ylp);
            chk("hold_ch", out_ch, h_ch);
        end
        held = out_valid && !out_ready;
        h_yu = YU; h_ylp = YLP; h_ch = out_ch;
        if (out_valid && out_ready) begin
            chk("result_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("out_ch", out_ch, e.ch);
                chk("yu", YU, e.yu);
                chk("ylp", YLP, e.ylp);
                pop_yu.push_back(int'(YU));
                pop_ylp.push_back(longint'(YLP));
            end
        end
        if (acc) begin
            c = (ch >= NCH) ? NCH - 1 : ch;
            yu = m_yu(wi & 4095, y & 8191);
            ylp = (yl_m[c] + yu - (yl_m[c] >> SS)) & ((longint'(1) << YLW) - 1);
            yl_m[c] = ylp;
            e.ch = c; e.yu = yu; e.ylp = ylp;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; in_valid = 1'b0; held = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_yu", YU, 0);
        chk("rst_ylp", YLP, 0);
        chk("rst_out_ch", out_ch, 0);
        m_reset();
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_release_ready", in_ready, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        repeat (6) cyc(0, 0, 0, 0, 1);
        chk("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        m_reset();
        // single sample, latency and limb behaviour
        do_reset();
        cyc(1, 0, 0, 544, 1);
        chk("lat_c0", ov, 0);
        cyc(0, 0, 0, 0, 1);
        chk("lat_c1", ov, 0);
        cyc(0, 0, 0, 0, 1);
        chk("lat_c2", ov, 1);
        drain();
        chk("t033_n", pop_yu.size(), 1);
        if (pop_yu.size() == 1) begin
`ifdef YU_LIMB_EN
            chk("t033_yu", pop_yu[0], 544);
            chk("t033_ylp", pop_ylp[0], 34816);
`else
            chk("t037_yu", pop_yu[0], 527);
            chk("t037_ylp", pop_ylp[0], 34799);
`endif
        end
        // back-to-back same channel exercises forwarding
        do_reset();
        cyc(1, 1, 1122, 544, 1);
        cyc(1, 1, 1122, 544, 1);
        drain();
        chk("t034_n", pop_ylp.size(), 2);
        if (pop_ylp.size() == 2) begin
            chk("t034_yu", pop_yu[0], 1649);
            chk("t034_ylp0", pop_ylp[0], 35921);
            chk("t034_ylp1", pop_ylp[1], 37009);
        end
        // interleaved channels stay independent
        do_reset();
        for (int i = 0; i < 4; i++) cyc(1, i % 2, 1122, 544, 1);
        drain();
        chk("t035_n", pop_ylp.size(), 4);
        if (pop_ylp.size() == 4) begin
            chk("t035_ch0", pop_ylp[0], 35921);
            chk("t035_ch1", pop_ylp[1], 35921);
            chk("t035_ch0b", pop_ylp[2], 37009);
        end
        // downstream stall
        do_reset();
        sent = 0;
        for (int i = 0; i < 5; i++) begin
            cyc(sent < 3, 2, 1122, 544, 0);
            if (acc) sent++;
            if (i >= 2) chk("t036_stall_ready", rdy, 0);
        end
        chk("t036_sent_in_stall", sent, 2);
        for (int k = 0; k < 10 && sent < 3; k++) begin
            cyc(1, 2, 1122, 544, 1);
            if (acc) sent++;
        end
        drain();
        chk("t036_n", pop_ylp.size(), 3);
        if (pop_ylp.size() == 3) begin
            chk("t036_ylp0", pop_ylp[0], 35921);
            chk("t036_ylp1", pop_ylp[1], 37009);
            chk("t036_ylp2", pop_ylp[2], 38080);
        end
        // reset with samples in flight restores the table
        do_reset();
        cyc(1, 0, 1122, 544, 1);
        cyc(1, 3, 1122, 544, 1);
        do_reset();
        for (int c = 0; c < NCH; c++) cyc(1, c, 1122, 544, 1);
        drain();
        chk("t038_n", pop_ylp.size(), NCH);
        for (int c = 0; c < NCH && c < pop_ylp.size(); c++) chk("t038_ylp", pop_ylp[c], 35921);
        // randomized traffic with random backpressure
        do_reset();
        for (int i = 0; i < 600; i++)
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, NCH - 1), $urandom_range(0, 4095),
                $urandom_range(0, 8191), $urandom_range(0, 9) < 7);
        drain();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
